seq_control_ws: RTL and testbench
=================================

Name: seq_control_ws

Overview:
Parametrised multi-cycle instruction sequencer for the A-series CPU. It is the successor to the existing sequence controller and adds:
- a variable-latency memory handshake (MEM_Req/MEM_Ack) with a timeout fault;
- illegal-opcode trapping;
- a halt/resume mechanism.

It sits between the IR/flag register and the datapath muxes/strobes, and decodes the 4-bit opcode in IR[DataWidth-1:DataWidth-4].

Parameters:
DataWidth, 16, IR width; opcode field = top 4 bits, CN = IR[DataWidth-5:DataWidth-6], JPLink = IR[DataWidth-5]
ALUOpSize, 4, width of ALU_Op
MemTimeout, 15, max cycles waiting for MEM_Ack before fault (>=1); counter width = clog2(MemTimeout+1)

Ports:
Clk  in  1  clock, all state on rising edge
Reset  in  1  synchronous, active-high
IR  in  DataWidth  current instruction register
ALU_FlgsIn  in  4  {V,N,C,Z} = [3:0]
MEM_Ack  in  1  memory completed access (read data valid same cycle)
Resume  in  1  leave halted state
MEM_Req  out  1  memory access request
MEM_Wr  out  1  1 = write, 0 = read (valid with MEM_Req)
ADDR_Src  out  2  00 PC, 10 zero-extended IR
IR_Ld  out  1  load IR
PC_Rst  out  1  reset PC
PC_Inc  out  1  increment PC
PC_Ld  out  1  load PC
PC_Src  out  2  00 branch addr, 01 return addr, 10 RegFile Src1
BRA_Src  out  1  1 sign-extended IR, 0 RegFile Src1
STK_Ld  out  1  push return address
REG_WE  out  1  register-file write
DATA_Src  out  2  00 zero-ext IR, 01 memory, 10 ALU
Src1_Sel  out  1  0 route Dest field, 1 Src1 field
ALU_Op  out  ALUOpSize  ALU operation
ALU_Ld  out  1  load ALU result register
FLG_Ld  out  1  load flags
FLG_Rst  out  1  clear flags
Halt  out  1  core halted
Fault  out  1  sticky: illegal opcode or memory timeout

Behaviour:
- All strobes are active-high. Outputs are combinational from the registered state and IR; default 0 (Src1_Sel default 1).
- Reset=1 sampled: state<=S_RESET, wait counter<=0, Fault<=0. Reset has priority over every other event, including mid-access and in halt.
- S_RESET: PC_Rst=1, FLG_Rst=1, all others 0; next S_FETCH.
- S_FETCH: MEM_Req=1, MEM_Wr=0, ADDR_Src=00.
  - MEM_Ack=1 in the same cycle: IR_Ld=1, PC_Inc=1, next S_DECODE.
  - Otherwise stay, wait counter +1.
- S_DECODE actions by opcode:
  - NOP(0): no action; next S_FETCH.
  - HLT(1): next S_HALT.
  - LDI(2): REG_WE=1, DATA_Src=00.
  - LD(3), ST(4), STX(5): next S_MEM.
  - JPL/JMP(6): PC_Ld=1, PC_Src=10, STK_Ld=~JPLink.
  - RET(7): PC_Ld=1, PC_Src=01.
  - BRD(8)/BRX(9): evaluate CN (00 Z, 01 !Z, 10 N!=V, 11 C).
    - Taken: PC_Ld=1, PC_Src=00, BRA_Src=1 (BRD) / 0 (BRX).
    - FLG_Rst=1 whether or not the branch is taken.
  - ADD..XOR(A..E): ALU_Op = opcode-0xA, ALU_Ld=1, FLG_Ld=1; next S_EXEC.
  - 0xF: Fault<=1; next S_HALT.
- S_MEM: MEM_Req=1, ADDR_Src=10.
  - LD: MEM_Wr=0; on ack, REG_WE=1, DATA_Src=01.
  - ST: MEM_Wr=1, Src1_Sel=0.
  - STX: MEM_Wr=1, Src1_Sel=1.
  - Stay until ack, then S_FETCH.
- S_EXEC: REG_WE=1, DATA_Src=10, ALU_Op held; next S_FETCH.
- Timeout: wait counter clears on every entry to S_FETCH/S_MEM. If the counter reaches MemTimeout without ack: drop MEM_Req, Fault<=1, next S_HALT. Ack in the same cycle as the count limit wins (no fault).
- S_HALT: Halt=1, all strobes 0.
  - Resume=1: next S_FETCH (Fault stays).
  - Resume while Fault=1 is ignored; only Reset clears Fault.
- Latency with a 0-wait ack (ack in request cycle):
  - NOP/HLT/LDI/JMP/RET/BR: 2 cycles.
  - LD/ST/STX/ALU: 3 cycles.
  - Each wait cycle adds 1.
- Illegal state encodings: next S_RESET.

Decomposition:
- Shared package seq_pkg: state encoding (S_RESET, S_FETCH, S_DECODE, S_MEM, S_EXEC, S_HALT), opcode constants, CN constants, DATA_Src/PC_Src/ADDR_Src selector constants, flag bit indices.
- One sub-module, branch_cond: combinational CN x flags -> take.

Test Plan:
- Reset=1 for 2 cycles, release -> PC_Rst=1 and FLG_Rst=1 during S_RESET; next cycle MEM_Req=1, ADDR_Src=00.
- Fetch with ack delayed 3 cycles, IR=0x2005 (LDI) -> MEM_Req held 4 cycles, IR_Ld/PC_Inc pulse only in ack cycle, then REG_WE=1, DATA_Src=00.
- IR=0x8400 (BNE) with Z=0 -> PC_Ld=1, BRA_Src=1, FLG_Rst=1; repeat with Z=1 -> PC_Ld=0, FLG_Rst=1.
- IR=0xB012 (SUB) -> decode ALU_Op=1, ALU_Ld=1, FLG_Ld=1; next cycle REG_WE=1, DATA_Src=10.
- LD with MEM_Ack never asserted, MemTimeout=15 -> after 15 wait cycles Fault=1, Halt=1; Resume ignored; Reset clears both.
- IR=0x1000 (HLT) -> Halt=1; Resume pulse -> S_FETCH next cycle; Reset asserted mid-S_MEM -> S_RESET next cycle, MEM_Req=0.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the A-series sequencer: state encoding, opcode map,
// branch-condition codes, datapath selector values and flag bit positions.
package seq_pkg;

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_MEM    = 3'd3,
        S_EXEC   = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_HLT = 4'h1;
    localparam logic [3:0] OP_LDI = 4'h2;
    localparam logic [3:0] OP_LD  = 4'h3;
    localparam logic [3:0] OP_ST  = 4'h4;
    localparam logic [3:0] OP_STX = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_RET = 4'h7;
    localparam logic [3:0] OP_BRD = 4'h8;
    localparam logic [3:0] OP_BRX = 4'h9;
    localparam logic [3:0] OP_ADD = 4'hA;
    localparam logic [3:0] OP_SUB = 4'hB;
    localparam logic [3:0] OP_AND = 4'hC;
    localparam logic [3:0] OP_OR  = 4'hD;
    localparam logic [3:0] OP_XOR = 4'hE;
    localparam logic [3:0] OP_ILL = 4'hF;

    localparam logic [1:0] CN_Z  = 2'b00;
    localparam logic [1:0] CN_NZ = 2'b01;
    localparam logic [1:0] CN_LT = 2'b10;
    localparam logic [1:0] CN_C  = 2'b11;

    localparam logic [1:0] DATA_SRC_IMM = 2'b00;
    localparam logic [1:0] DATA_SRC_MEM = 2'b01;
    localparam logic [1:0] DATA_SRC_ALU = 2'b10;

    localparam logic [1:0] PC_SRC_BRA = 2'b00;
    localparam logic [1:0] PC_SRC_RET = 2'b01;
    localparam logic [1:0] PC_SRC_REG = 2'b10;

    localparam logic [1:0] ADDR_SRC_PC = 2'b00;
    localparam logic [1:0] ADDR_SRC_IR = 2'b10;

    localparam int unsigned FLG_Z = 0;
    localparam int unsigned FLG_C = 1;
    localparam int unsigned FLG_N = 2;
    localparam int unsigned FLG_V = 3;

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluator: maps a 2-bit condition code and the {V,N,C,Z}
// flag vector onto a single take/not-take decision.
module branch_cond
    import seq_pkg::*;
(
    input  logic [1:0] cn,
    input  logic [3:0] flags,
    output logic       take
);

    always_comb begin
        take = 1'b0;
        case (cn)
            CN_Z:    take = flags[FLG_Z];
            CN_NZ:   take = ~flags[FLG_Z];
            CN_LT:   take = flags[FLG_N] ^ flags[FLG_V];
            CN_C:    take = flags[FLG_C];
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/seq_control_ws.sv
// Multi-cycle instruction sequencer with a variable-latency memory handshake,
// access timeout, illegal-opcode trap and halt/resume.
module seq_control_ws
    import seq_pkg::*;
#(
    parameter int unsigned DataWidth  = 16,
    parameter int unsigned ALUOpSize  = 4,
    parameter int unsigned MemTimeout = 15
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [DataWidth-1:0] IR,
    input  logic [3:0]           ALU_FlgsIn,
    input  logic                 MEM_Ack,
    input  logic                 Resume,
    output logic                 MEM_Req,
    output logic                 MEM_Wr,
    output logic [1:0]           ADDR_Src,
    output logic                 IR_Ld,
    output logic                 PC_Rst,
    output logic                 PC_Inc,
    output logic                 PC_Ld,
    output logic [1:0]           PC_Src,
    output logic                 BRA_Src,
    output logic                 STK_Ld,
    output logic                 REG_WE,
    output logic [1:0]           DATA_Src,
    output logic                 Src1_Sel,
    output logic [ALUOpSize-1:0] ALU_Op,
    output logic                 ALU_Ld,
    output logic                 FLG_Ld,
    output logic                 FLG_Rst,
    output logic                 Halt,
    output logic                 Fault
);

    localparam int unsigned CntWidth = $clog2(MemTimeout + 1);

    state_e                state_q, state_d;
    logic [CntWidth-1:0]   wait_cnt_q, wait_cnt_d;
    logic                  fault_q, fault_d;

    logic [3:0]            opcode;
    logic [1:0]            cn;
    logic                  jp_link;
    logic                  br_take;
    logic                  wait_limit;
    logic [ALUOpSize-1:0]  alu_op_val;
    logic                  unused_ir_low;

    assign opcode        = IR[DataWidth-1 -: 4];
    assign cn            = IR[DataWidth-5 -: 2];
    assign jp_link       = IR[DataWidth-5];
    assign alu_op_val    = ALUOpSize'(opcode - OP_ADD);
    assign wait_limit    = (wait_cnt_q == CntWidth'(MemTimeout));
    assign unused_ir_low = ^IR[DataWidth-7:0];

    branch_cond u_branch_cond (
        .cn    (cn),
        .flags (ALU_FlgsIn),
        .take  (br_take)
    );

    // NOTE: every output and next-state signal gets a default before the case so no path leaves one unassigned (which would infer a latch).
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        fault_d    = fault_q;
        MEM_Req    = 1'b0;
        MEM_Wr     = 1'b0;
        ADDR_Src   = ADDR_SRC_PC;
        IR_Ld      = 1'b0;
        PC_Rst     = 1'b0;
        PC_Inc     = 1'b0;
        PC_Ld      = 1'b0;
        PC_Src     = PC_SRC_BRA;
        BRA_Src    = 1'b0;
        STK_Ld     = 1'b0;
        REG_WE     = 1'b0;
        DATA_Src   = DATA_SRC_IMM;
        Src1_Sel   = 1'b1;
        ALU_Op     = '0;
        ALU_Ld     = 1'b0;
        FLG_Ld     = 1'b0;
        FLG_Rst    = 1'b0;
        Halt       = 1'b0;

        case (state_q)
            S_RESET: begin
                PC_Rst  = 1'b1;
                FLG_Rst = 1'b1;
                state_d = S_FETCH;
            end

            S_FETCH: begin
                MEM_Req  = 1'b1;
                ADDR_Src = ADDR_SRC_PC;
                if (MEM_Ack) begin
                    IR_Ld   = 1'b1;
                    PC_Inc  = 1'b1;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                state_d = S_FETCH;
                case (opcode)
                    OP_NOP: ;
                    OP_HLT: state_d = S_HALT;
                    OP_LDI: begin
                        REG_WE   = 1'b1;
                        DATA_Src = DATA_SRC_IMM;
                    end
                    OP_LD, OP_ST, OP_STX: state_d = S_MEM;
                    OP_JMP: begin
                        PC_Ld  = 1'b1;
                        PC_Src = PC_SRC_REG;
                        STK_Ld = ~jp_link;
                    end
                    OP_RET: begin
                        PC_Ld  = 1'b1;
                        PC_Src = PC_SRC_RET;
                    end
                    OP_BRD, OP_BRX: begin
                        FLG_Rst = 1'b1;
                        if (br_take) begin
                            PC_Ld   = 1'b1;
                            PC_Src  = PC_SRC_BRA;
                            BRA_Src = (opcode == OP_BRD);
                        end
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        ALU_Op  = alu_op_val;
                        ALU_Ld  = 1'b1;
                        FLG_Ld  = 1'b1;
                        state_d = S_EXEC;
                    end
                    default: begin
                        fault_d = 1'b1;
                        state_d = S_HALT;
                    end
                endcase
            end

            S_MEM: begin
                MEM_Req  = 1'b1;
                ADDR_Src = ADDR_SRC_IR;
                case (opcode)
                    OP_ST: begin
                        MEM_Wr   = 1'b1;
                        Src1_Sel = 1'b0;
                    end
                    OP_STX: begin
                        MEM_Wr   = 1'b1;
                        Src1_Sel = 1'b1;
                    end
                    default: begin
                        if (MEM_Ack) begin
                            REG_WE   = 1'b1;
                            DATA_Src = DATA_SRC_MEM;
                        end
                    end
                endcase
                if (MEM_Ack) state_d = S_FETCH;
            end

            S_EXEC: begin
                REG_WE   = 1'b1;
                DATA_Src = DATA_SRC_ALU;
                ALU_Op   = alu_op_val;
                state_d  = S_FETCH;
            end

            S_HALT: begin
                Halt = 1'b1;
                if (Resume && !fault_q) state_d = S_FETCH;
            end

            default: state_d = S_RESET;
        endcase

        // Shared wait/timeout handling for both memory phases; an ack in the
        // limit cycle has already advanced the state above and wins.
        if ((state_q == S_FETCH || state_q == S_MEM) && !MEM_Ack) begin
            if (wait_limit) begin
                fault_d = 1'b1;
                state_d = S_HALT;
            end else begin
                wait_cnt_d = wait_cnt_q + CntWidth'(1);
            end
        end
    end

    assign Fault = fault_q;

    // NOTE: Reset is synchronous and checked first, so it overrides any in-flight access or halt.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= S_RESET;
            wait_cnt_q <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            fault_q    <= fault_d;
        end
    end

endmodule

// File: tb/tb_seq_control_ws.sv
// Self-checking bench for seq_control_ws: table of decode vectors, directed
// corner sequences, and random instruction streams against a cycle-list model.
module tb_seq_control_ws;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int MT = 15;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic [DW-1:0] IR = '0;
    logic [3:0]    ALU_FlgsIn = '0;
    logic          MEM_Ack = 1'b0;
    logic          Resume = 1'b0;
    logic          MEM_Req, MEM_Wr, IR_Ld, PC_Rst, PC_Inc, PC_Ld, BRA_Src, STK_Ld;
    logic          REG_WE, Src1_Sel, ALU_Ld, FLG_Ld, FLG_Rst, Halt, Fault;
    logic [1:0]    ADDR_Src, PC_Src, DATA_Src;
    logic [AW-1:0] ALU_Op;

    seq_control_ws #(.DataWidth(DW), .ALUOpSize(AW), .MemTimeout(MT)) dut (
        .Clk(Clk), .Reset(Reset), .IR(IR), .ALU_FlgsIn(ALU_FlgsIn),
        .MEM_Ack(MEM_Ack), .Resume(Resume), .MEM_Req(MEM_Req), .MEM_Wr(MEM_Wr),
        .ADDR_Src(ADDR_Src), .IR_Ld(IR_Ld), .PC_Rst(PC_Rst), .PC_Inc(PC_Inc),
        .PC_Ld(PC_Ld), .PC_Src(PC_Src), .BRA_Src(BRA_Src), .STK_Ld(STK_Ld),
        .REG_WE(REG_WE), .DATA_Src(DATA_Src), .Src1_Sel(Src1_Sel), .ALU_Op(ALU_Op),
        .ALU_Ld(ALU_Ld), .FLG_Ld(FLG_Ld), .FLG_Rst(FLG_Rst), .Halt(Halt), .Fault(Fault)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic          mem_req;
        logic          mem_wr;
        logic [1:0]    addr_src;
        logic          ir_ld;
        logic          pc_rst;
        logic          pc_inc;
        logic          pc_ld;
        logic [1:0]    pc_src;
        logic          bra_src;
        logic          stk_ld;
        logic          reg_we;
        logic [1:0]    data_src;
        logic          src1_sel;
        logic [AW-1:0] alu_op;
        logic          alu_ld;
        logic          flg_ld;
        logic          flg_rst;
        logic          halt;
        logic          fault;
    } out_t;

    typedef struct {
        logic          rst;
        logic [DW-1:0] ir;
        logic [3:0]    flags;
        logic          ack;
        logic          resume;
        out_t          exp;
        string         tag;
    } cyc_t;

    typedef struct {
        logic [DW-1:0] ir;
        logic [3:0]    flags;
        out_t          exp;
        string         tag;
    } vec_t;

    cyc_t          q[$];
    vec_t          tv[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    logic          m_fault = 1'b0;
    logic [DW-1:0] cur_ir = '0;
    logic [3:0]    cur_flags = '0;

    function automatic logic rnd();
        return 1'($urandom);
    endfunction

    function automatic out_t idle();
        out_t o = '0;
        o.src1_sel = 1'b1;
        return o;
    endfunction

    function automatic out_t sample();
        out_t o;
        o.mem_req = MEM_Req;   o.mem_wr = MEM_Wr;     o.addr_src = ADDR_Src;
        o.ir_ld = IR_Ld;       o.pc_rst = PC_Rst;     o.pc_inc = PC_Inc;
        o.pc_ld = PC_Ld;       o.pc_src = PC_Src;     o.bra_src = BRA_Src;
        o.stk_ld = STK_Ld;     o.reg_we = REG_WE;     o.data_src = DATA_Src;
        o.src1_sel = Src1_Sel; o.alu_op = ALU_Op;     o.alu_ld = ALU_Ld;
        o.flg_ld = FLG_Ld;     o.flg_rst = FLG_Rst;   o.halt = Halt;
        o.fault = Fault;
        return o;
    endfunction

    // Decode-cycle strobes as literal table entries.
    function automatic out_t dx(logic pc_ld, logic [1:0] pc_src, logic bra_src, logic stk_ld,
                                logic reg_we, logic [AW-1:0] alu_op, logic alu_ld,
                                logic flg_ld, logic flg_rst);
        out_t o = idle();
        o.pc_ld = pc_ld;   o.pc_src = pc_src; o.bra_src = bra_src; o.stk_ld = stk_ld;
        o.reg_we = reg_we; o.alu_op = alu_op; o.alu_ld = alu_ld;   o.flg_ld = flg_ld;
        o.flg_rst = flg_rst;
        return o;
    endfunction

    task automatic check(string name, out_t got, out_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h required %h", name, $time, got, exp);
        end
    endtask

    task automatic push(logic ack, logic resume, out_t exp, string tag, logic rst = 1'b0);
        cyc_t c;
        c.rst = rst; c.ir = cur_ir; c.flags = cur_flags; c.ack = ack; c.resume = resume;
        c.exp = exp; c.exp.fault = m_fault; c.tag = tag;
        q.push_back(c);
    endtask

    // Instruction-level reference: what each cycle of an instruction must show.
    function automatic out_t decode_exp(logic [DW-1:0] ir, logic [3:0] f);
        out_t       o = idle();
        logic [3:0] op = ir[DW-1 -: 4];
        logic [1:0] cn = ir[DW-5 -: 2];
        bit         take;
        case (cn)
            2'd0:    take = f[0];
            2'd1:    take = !f[0];
            2'd2:    take = (f[2] != f[3]);
            default: take = f[1];
        endcase
        if (op == 4'h2) begin
            o.reg_we = 1'b1;
        end else if (op == 4'h6) begin
            o.pc_ld = 1'b1; o.pc_src = 2'b10; o.stk_ld = !ir[DW-5];
        end else if (op == 4'h7) begin
            o.pc_ld = 1'b1; o.pc_src = 2'b01;
        end else if (op == 4'h8 || op == 4'h9) begin
            o.flg_rst = 1'b1;
            if (take) begin
                o.pc_ld = 1'b1; o.pc_src = 2'b00; o.bra_src = (op == 4'h8);
            end
        end else if (op >= 4'hA && op <= 4'hE) begin
            o.alu_op = AW'(op - 4'hA); o.alu_ld = 1'b1; o.flg_ld = 1'b1;
        end
        return o;
    endfunction

    task automatic gen_wait(out_t base, int waits, string tag, output bit acked);
        if (waits <= MT) begin
            repeat (waits) push(1'b0, rnd(), base, tag);
            acked = 1'b1;
        end else begin
            repeat (MT + 1) push(1'b0, rnd(), base, {tag, "-timeout"});
            m_fault = 1'b1;
            acked = 1'b0;
        end
    endtask

    task automatic gen_halt(int idle_cycles, bit do_resume);
        out_t h = idle();
        h.halt = 1'b1;
        repeat (idle_cycles) push(rnd(), 1'b0, h, "halt");
        if (do_resume) push(rnd(), 1'b1, h, "halt-resume");
    endtask

    task automatic gen_reset(out_t cur, string tag);
        out_t r = idle();
        r.pc_rst = 1'b1; r.flg_rst = 1'b1;
        push(1'b0, 1'b0, cur, tag, 1'b1);
        m_fault = 1'b0;
        push(rnd(), rnd(), r, "reset-state");
    endtask

    task automatic gen_instr(logic [DW-1:0] ir, logic [3:0] flags, int wf, int wm, int hidle);
        out_t       fb = idle();
        out_t       d, mb, e;
        logic [3:0] op = ir[DW-1 -: 4];
        bit         acked;
        cur_ir = ir; cur_flags = flags;
        fb.mem_req = 1'b1;
        gen_wait(fb, wf, "fetch-wait", acked);
        if (!acked) begin
            gen_halt(hidle, 1'b1);
            return;
        end
        d = fb; d.ir_ld = 1'b1; d.pc_inc = 1'b1;
        push(1'b1, rnd(), d, "fetch-ack");
        push(rnd(), rnd(), decode_exp(ir, flags), "decode");
        case (op)
            4'h1: gen_halt(hidle, 1'b1);
            4'h3, 4'h4, 4'h5: begin
                mb = idle();
                mb.mem_req = 1'b1; mb.addr_src = 2'b10;
                mb.mem_wr = (op != 4'h3); mb.src1_sel = (op != 4'h4);
                gen_wait(mb, wm, "mem-wait", acked);
                if (acked) begin
                    if (op == 4'h3) begin
                        mb.reg_we = 1'b1; mb.data_src = 2'b01;
                    end
                    push(1'b1, rnd(), mb, "mem-ack");
                end else begin
                    gen_halt(hidle, 1'b1);
                end
            end
            4'hA, 4'hB, 4'hC, 4'hD, 4'hE: begin
                e = idle();
                e.reg_we = 1'b1; e.data_src = 2'b10; e.alu_op = AW'(op - 4'hA);
                push(rnd(), rnd(), e, "exec");
            end
            4'hF: begin
                m_fault = 1'b1;
                gen_halt(hidle, 1'b1);
            end
            default: ;
        endcase
    endtask

    task automatic play();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            Reset = c.rst; IR = c.ir; ALU_FlgsIn = c.flags; MEM_Ack = c.ack; Resume = c.resume;
            @(negedge Clk);
            check(c.tag, sample(), c.exp);
            @(posedge Clk);
            #1;
        end
        Reset = 1'b0;
    endtask

    task automatic reset_seq();
        out_t r = idle();
        r.pc_rst = 1'b1; r.flg_rst = 1'b1;
        Reset = 1'b1; MEM_Ack = 1'b0; Resume = 1'b0;
        @(posedge Clk);
        #1;
        @(negedge Clk);
        check("reset-held", sample(), r);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        m_fault = 1'b0;
        push(rnd(), rnd(), r, "reset-release");
    endtask

    task automatic add_vec(logic [DW-1:0] ir, logic [3:0] flags, out_t exp, string tag);
        vec_t v;
        v.ir = ir; v.flags = flags; v.exp = exp; v.tag = tag;
        tv.push_back(v);
    endtask

    initial begin
        out_t fb, h, mb, d;
        int   wf, wm;

        // Decode table: {IR, flags} -> strobes in the decode cycle.
        add_vec(16'h0000, 4'h0, dx(0, 2'd0, 0, 0, 0, 4'd0, 0, 0, 0), "tv-nop");
        add_vec(16'h2005, 4'h0, dx(0, 2'd0, 0, 0, 1, 4'd0, 0, 0, 0), "tv-ldi");
        add_vec(16'h6000, 4'h0, dx(1, 2'd2, 0, 1, 0, 4'd0, 0, 0, 0), "tv-jpl");
        add_vec(16'h6800, 4'h0, dx(1, 2'd2, 0, 0, 0, 4'd0, 0, 0, 0), "tv-jmp");
        add_vec(16'h7000, 4'h0, dx(1, 2'd1, 0, 0, 0, 4'd0, 0, 0, 0), "tv-ret");
        add_vec(16'h8400, 4'h0, dx(1, 2'd0, 1, 0, 0, 4'd0, 0, 0, 1), "tv-bne-taken");
        add_vec(16'h8400, 4'h1, dx(0, 2'd0, 0, 0, 0, 4'd0, 0, 0, 1), "tv-bne-not");
        add_vec(16'h8000, 4'h1, dx(1, 2'd0, 1, 0, 0, 4'd0, 0, 0, 1), "tv-beq-taken");
        add_vec(16'h9C00, 4'h2, dx(1, 2'd0, 0, 0, 0, 4'd0, 0, 0, 1), "tv-brx-c-taken");
        add_vec(16'h9C00, 4'hD, dx(0, 2'd0, 0, 0, 0, 4'd0, 0, 0, 1), "tv-brx-c-not");
        add_vec(16'h8800, 4'h4, dx(1, 2'd0, 1, 0, 0, 4'd0, 0, 0, 1), "tv-blt-taken");
        add_vec(16'h8800, 4'hC, dx(0, 2'd0, 0, 0, 0, 4'd0, 0, 0, 1), "tv-blt-not");
        add_vec(16'hA000, 4'h0, dx(0, 2'd0, 0, 0, 0, 4'd0, 1, 1, 0), "tv-add");
        add_vec(16'hB012, 4'h0, dx(0, 2'd0, 0, 0, 0, 4'd1, 1, 1, 0), "tv-sub");
        add_vec(16'hE000, 4'h0, dx(0, 2'd0, 0, 0, 0, 4'd4, 1, 1, 0), "tv-xor");
        add_vec(16'h3000, 4'h0, dx(0, 2'd0, 0, 0, 0, 4'd0, 0, 0, 0), "tv-ld");
        add_vec(16'hF000, 4'h0, dx(0, 2'd0, 0, 0, 0, 4'd0, 0, 0, 0), "tv-illegal");
        add_vec(16'h1000, 4'h0, dx(0, 2'd0, 0, 0, 0, 4'd0, 0, 0, 0), "tv-hlt");

        fb = idle(); fb.mem_req = 1'b1;
        d = fb; d.ir_ld = 1'b1; d.pc_inc = 1'b1;
        foreach (tv[i]) begin
            cur_ir = tv[i].ir; cur_flags = tv[i].flags;
            reset_seq();
            push(1'b1, 1'b0, d, {tv[i].tag, "-fetch"});
            push(1'b0, 1'b0, tv[i].exp, tv[i].tag);
            play();
        end

        // Delayed fetch ack, then branch both ways and an ALU op.
        reset_seq();
        gen_instr(16'h2005, 4'h0, 3, 0, 0);
        gen_instr(16'h8400, 4'h0, 0, 0, 0);
        gen_instr(16'h8400, 4'h1, 0, 0, 0);
        gen_instr(16'hB012, 4'h0, 0, 0, 0);
        play();

        // Ack arriving exactly at the timeout limit wins in both phases.
        gen_instr(16'h3000, 4'h0, MT, MT, 0);
        gen_instr(16'h4000, 4'h0, MT, MT, 0);
        gen_instr(16'h5000, 4'h0, 1, MT, 0);
        play();

        // Load with no ack: fault, halt, resume ignored, reset clears.
        h = idle(); h.halt = 1'b1;
        gen_instr(16'h3000, 4'h0, 0, MT + 1, 2);
        gen_halt(2, 1'b1);
        gen_reset(h, "reset-in-halt");
        gen_instr(16'h0000, 4'h0, 0, 0, 0);
        play();

        // Fetch timeout.
        gen_instr(16'h0000, 4'h0, MT + 1, 0, 1);
        gen_reset(h, "reset-in-halt");
        play();

        // HLT then resume, followed by a normal instruction.
        gen_instr(16'h1000, 4'h0, 0, 0, 3);
        gen_instr(16'h2005, 4'h0, 0, 0, 0);
        play();

        // Illegal opcode traps; resume ignored.
        gen_instr(16'hF000, 4'h0, 0, 0, 2);
        gen_halt(1, 1'b1);
        gen_reset(h, "reset-in-halt");
        play();

        // Reset in the middle of a memory access.
        gen_instr(16'h0000, 4'h0, 0, 0, 0);
        cur_ir = 16'h4000;
        push(1'b1, 1'b0, d, "fetch-ack");
        push(1'b0, 1'b0, decode_exp(16'h4000, 4'h0), "decode");
        mb = idle(); mb.mem_req = 1'b1; mb.addr_src = 2'b10; mb.mem_wr = 1'b1; mb.src1_sel = 1'b0;
        push(1'b0, 1'b0, mb, "mem-wait");
        gen_reset(mb, "reset-in-mem");
        gen_instr(16'h2005, 4'h0, 0, 0, 0);
        play();

        // Random instruction streams (no illegal opcodes).
        reset_seq();
        for (int n = 0; n < 400; n++) begin
            wf = ($urandom_range(0, 9) == 0) ? MT : int'($urandom_range(0, 3));
            wm = ($urandom_range(0, 9) == 0) ? MT : int'($urandom_range(0, 3));
            gen_instr({4'($urandom_range(0, 14)), 12'($urandom)}, 4'($urandom), wf, wm,
                      int'($urandom_range(0, 3)));
            play();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
